// File: rtl/sfm_tcdm_mem_responder.sv
// TCDM slave memory for the softmax accelerator: shared word memory plus per-port response FIFOs.
// Define SFM_TCDM_RESP_STALL_EN to add LFSR-driven pseudo-random grant stalls on every port.
module sfm_tcdm_mem_responder #(
    parameter int          MP         = 4,
    parameter int          MEM_WORDS  = 4096,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          RESP_DEPTH = 2,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [MP-1:0]    tcdm_req_i,
    output logic [MP-1:0]    tcdm_gnt_o,
    input  logic [MP*32-1:0] tcdm_add_i,
    input  logic [MP-1:0]    tcdm_wen_i,
    input  logic [MP*4-1:0]  tcdm_be_i,
    input  logic [MP*32-1:0] tcdm_data_i,
    input  logic [MP*8-1:0]  tcdm_id_i,
    input  logic [MP-1:0]    tcdm_r_ready_i,
    output logic [MP-1:0]    tcdm_r_valid_o,
    output logic [MP*32-1:0] tcdm_r_data_o,
    output logic [MP*8-1:0]  tcdm_r_id_o,
    output logic [15:0]      err_cnt_o
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(RESP_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(RESP_DEPTH - 1);
    localparam logic [29:0]   MW_C     = 30'(MEM_WORDS);

    logic [31:0]                r_mem       [MEM_WORDS];
    logic [31:0]                r_fifo_data [MP][RESP_DEPTH];
    logic [7:0]                 r_fifo_id   [MP][RESP_DEPTH];
    logic [MP-1:0][PW-1:0]      r_wptr;
    logic [MP-1:0][PW-1:0]      r_rptr;
    logic [MP-1:0][CW-1:0]      r_cnt;
    logic [15:0]                r_err_cnt;

    logic [MP-1:0]              w_stall;
    logic [MP-1:0]              w_hs;
    logic [MP-1:0]              w_inr;
    logic [MP-1:0]              w_oor;
    logic [MP-1:0]              w_pop;
    logic [31:0]                w_off       [MP];
    logic [AW-1:0]              w_idx       [MP];
    logic [31:0]                w_push_data [MP];
    logic [16:0]                w_err_sum;
    logic                       w_unused_lsb;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
    endfunction

`ifdef SFM_TCDM_RESP_STALL_EN
    logic [MP-1:0][15:0] r_lfsr;

    // Fibonacci LFSR, taps 16,14,13,11, free-running per port
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int p = 0; p < MP; p++) begin
                r_lfsr[p] <= LFSR_SEED ^ 16'(p);
            end
        end else begin
            for (int p = 0; p < MP; p++) begin
                r_lfsr[p] <= {r_lfsr[p][14:0],
                              r_lfsr[p][15] ^ r_lfsr[p][13] ^ r_lfsr[p][12] ^ r_lfsr[p][10]};
            end
        end
    end

    always_comb begin
        w_stall = '0;
        for (int p = 0; p < MP; p++) begin
            w_stall[p] = r_lfsr[p][0] & r_lfsr[p][1];
        end
    end
`else
    logic [15:0] w_unused_seed;
    assign w_unused_seed = LFSR_SEED;
    assign w_stall       = '0;
`endif

    // Grant uses the registered count only, so a full FIFO never grants on a same-cycle pop
    always_comb begin
        tcdm_gnt_o     = '0;
        tcdm_r_valid_o = '0;
        tcdm_r_data_o  = '0;
        tcdm_r_id_o    = '0;
        for (int p = 0; p < MP; p++) begin
            tcdm_gnt_o[p]     = rst_ni & tcdm_req_i[p] & (r_cnt[p] < DEPTH_C) & ~w_stall[p];
            tcdm_r_valid_o[p] = rst_ni & (r_cnt[p] != '0);
            if (tcdm_r_valid_o[p]) begin
                tcdm_r_data_o[p*32 +: 32] = r_fifo_data[p][r_rptr[p]];
                tcdm_r_id_o[p*8 +: 8]     = r_fifo_id[p][r_rptr[p]];
            end
        end
        err_cnt_o = rst_ni ? r_err_cnt : '0;
    end

    always_comb begin
        w_hs         = '0;
        w_inr        = '0;
        w_oor        = '0;
        w_pop        = '0;
        w_unused_lsb = 1'b0;
        w_err_sum    = {1'b0, r_err_cnt};
        for (int p = 0; p < MP; p++) begin
            w_off[p]       = tcdm_add_i[p*32 +: 32] - BASE_ADDR;
            w_idx[p]       = w_off[p][AW+1:2];
            w_inr[p]       = (tcdm_add_i[p*32 +: 32] >= BASE_ADDR) && (w_off[p][31:2] < MW_C);
            w_hs[p]        = tcdm_req_i[p] & tcdm_gnt_o[p];
            w_oor[p]       = w_hs[p] & ~w_inr[p];
            w_pop[p]       = tcdm_r_valid_o[p] & tcdm_r_ready_i[p];
            w_push_data[p] = tcdm_wen_i[p] ? (w_inr[p] ? r_mem[w_idx[p]] : ERR_DATA) : 32'h0;
            w_err_sum      = w_err_sum + 17'(w_oor[p]);
            w_unused_lsb   = w_unused_lsb ^ (^w_off[p][1:0]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_cnt     <= '0;
            r_err_cnt <= '0;
        end else begin
            for (int p = 0; p < MP; p++) begin
                if (w_hs[p]) begin
                    r_wptr[p] <= ptr_inc(r_wptr[p]);
                end
                if (w_pop[p]) begin
                    r_rptr[p] <= ptr_inc(r_rptr[p]);
                end
                if (w_hs[p] && !w_pop[p]) begin
                    r_cnt[p] <= r_cnt[p] + CW'(1);
                end else if (!w_hs[p] && w_pop[p]) begin
                    r_cnt[p] <= r_cnt[p] - CW'(1);
                end
            end
            r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    // Later ports overwrite earlier ones byte-wise, so the highest port index wins
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < MP; p++) begin
            if (w_hs[p]) begin
                r_fifo_data[p][r_wptr[p]] <= w_push_data[p];
                r_fifo_id[p][r_wptr[p]]   <= tcdm_id_i[p*8 +: 8];
                if (!tcdm_wen_i[p] && w_inr[p]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (tcdm_be_i[p*4 + b]) begin
                            r_mem[w_idx[p]][b*8 +: 8] <= tcdm_data_i[p*32 + b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int p = 0; p < MP; p++) begin
                assert (r_cnt[p] <= DEPTH_C);
                assert (!(w_pop[p] && (r_cnt[p] == '0)));
            end
        end
    end
`endif

endmodule
